// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter and the MMU-side request path.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {FREE, OWN0, OWN1} arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Grant function for the two-requester arbiter; purely combinational, one-hot or zero.
// A lock owner excludes the other requester; otherwise the anti-starvation limit, then round-robin.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  arb_state_t        state,
  input  logic              last,
  input  logic [WAIT_W-1:0] wait_cnt,
  input  logic [1:0]        req,
  output logic [1:0]        gnt
);

  always_comb begin
    gnt = 2'b00;
    case (state)
      OWN0:    gnt = {1'b0, req[0]};
      OWN1:    gnt = {req[1], 1'b0};
      default: begin
        if (req == 2'b11) begin
          if (wait_cnt == WAIT_W'(MAX_WAIT)) gnt = 2'b10;
          else                               gnt = last ? 2'b01 : 2'b10;
        end else begin
          gnt = req;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-ported memory; grant combinational, issue 1 cycle later, read data 2 cycles after grant.
// One access per cycle with no bubbles; a losing requester holds req until granted.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [1:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_t        state;
  logic              last;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        pick_gnt;
  logic              win;
  mem_req_t          sel;
  logic              iss_rd;
  logic              iss_id;

  arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_pick (
    .state    (state),
    .last     (last),
    .wait_cnt (wait_cnt),
    .req      (req),
    .gnt      (pick_gnt)
  );

  assign gnt = reset ? 2'b00 : pick_gnt;
  assign win = gnt[1];

  always_comb begin
    sel       = '0;
    sel.we    = win ? we[1]  : we[0];
    sel.addr  = win ? addr1  : addr0;
    sel.wdata = win ? wdata1 : wdata0;
  end

  // Ownership and fairness state.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state    <= FREE;
      last     <= 1'b1;
      wait_cnt <= '0;
    end else begin
      if (|gnt) begin
        last  <= win;
        state <= lock[win] ? (win ? OWN1 : OWN0) : FREE;
      end
      if (!req[1] || gnt[1])
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Issue stage, then return stage tagged with the issuing requester.
  always_ff @(posedge clkin) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_w_en  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      iss_rd    <= 1'b0;
      iss_id    <= 1'b0;
      rvalid    <= 2'b00;
    end else begin
      mem_en <= |gnt;
      iss_rd <= (|gnt) & ~sel.we;
      iss_id <= win;
      if (|gnt) begin
        mem_w_en  <= sel.we;
        mem_addr  <= sel.addr;
        mem_wdata <= sel.wdata;
      end else begin
        mem_w_en  <= 1'b0;
      end
      rvalid <= iss_rd ? id_onehot(iss_id) : 2'b00;
    end
  end

  // Memory data arrives in the rvalid cycle; masked to zero otherwise.
  assign rdata = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, a transaction-level reference model and a small memory.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int HIST     = 4096;

  logic        clkin = 1'b0;
  logic        reset;
  logic [1:0]  req, we, lock;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_w_en;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clkin     (clkin),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clkin = ~clkin;

  // Synchronous single-port memory behind the arbiter, plus the model's shadow copy.
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    mem[16]     = 16'hBEEF;
    ref_mem[16] = 16'hBEEF;
    mem_rdata   = 16'h0000;
  end

  always @(posedge clkin) begin
    if (mem_en && mem_w_en)  mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_w_en) mem_rdata          <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: ownership, fairness and a per-cycle history of accepted accesses.
  int          cyc     = 0;
  bit          started = 1'b0;
  int          m_owner = -1;
  int          m_last  = 1;
  int          m_wait  = 0;
  logic [15:0] h_addr  = 16'h0;
  logic [15:0] h_wdata = 16'h0;
  bit          acc_vld [0:HIST-1];
  bit          acc_we  [0:HIST-1];
  bit          acc_id  [0:HIST-1];
  bit          rst_h   [0:HIST-1];
  logic [15:0] acc_rd  [0:HIST-1];
  logic [15:0] ma, md;

  function automatic int winner();
    if (reset)        return -1;
    if (m_owner == 0) return req[0] ? 0 : -1;
    if (m_owner == 1) return req[1] ? 1 : -1;
    if (req == 2'b11) return (m_wait == MAX_WAIT) ? 1 : ((m_last == 1) ? 0 : 1);
    if (req[0])       return 0;
    if (req[1])       return 1;
    return -1;
  endfunction

  initial begin
    forever begin
      int          w;
      logic [1:0]  eg, erv;
      @(negedge clkin);
      w  = winner();
      eg = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
      if (started) begin
        chk("model_gnt",       gnt,       eg);
        chk("model_mem_en",    mem_en,    acc_vld[cyc-1]);
        chk("model_mem_w_en",  mem_w_en,  acc_vld[cyc-1] && acc_we[cyc-1]);
        chk("model_mem_addr",  mem_addr,  h_addr);
        chk("model_mem_wdata", mem_wdata, h_wdata);
        erv = 2'b00;
        if (cyc >= 2 && acc_vld[cyc-2] && !acc_we[cyc-2] && !rst_h[cyc-1])
          erv = acc_id[cyc-2] ? 2'b10 : 2'b01;
        chk("model_rvalid", rvalid, erv);
        if (erv != 2'b00) chk("model_rdata", rdata, acc_rd[cyc-2]);
      end
      // Advance the model across the coming rising edge.
      rst_h[cyc] = reset;
      if (reset) begin
        m_owner      = -1;
        m_last       = 1;
        m_wait       = 0;
        h_addr       = 16'h0;
        h_wdata      = 16'h0;
        acc_vld[cyc] = 1'b0;
        started      = 1'b1;
      end else begin
        acc_vld[cyc] = (w >= 0);
        if (w >= 0) begin
          ma           = (w == 1) ? addr1  : addr0;
          md           = (w == 1) ? wdata1 : wdata0;
          acc_id[cyc]  = (w == 1);
          acc_we[cyc]  = we[w];
          acc_rd[cyc]  = ref_mem[ma[7:0]];
          if (we[w]) ref_mem[ma[7:0]] = md;
          h_addr       = ma;
          h_wdata      = md;
          m_last       = w;
          m_owner      = lock[w] ? w : -1;
        end
        if (req[1] && w != 1) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else                  m_wait = 0;
      end
      cyc++;
    end
  end

  task automatic step(input logic rst, input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                      input logic [15:0] a0, input logic [15:0] d0,
                      input logic [15:0] a1, input logic [15:0] d1);
    @(posedge clkin);
    #1;
    reset = rst; req = r; we = w; lock = l;
    addr0 = a0; wdata0 = d0; addr1 = a1; wdata1 = d1;
    @(negedge clkin);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; we = 2'b00; lock = 2'b00;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    step(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    step(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    idle();
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_mem_addr", mem_addr, 16'h0);
    chk("reset_rvalid", rvalid, 2'b00);

    // Single read from requester 0.
    step(1'b0, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
    chk("rd_gnt", gnt, 2'b01);
    idle();
    chk("rd_mem_en", mem_en, 1'b1);
    chk("rd_mem_addr", mem_addr, 16'h0010);
    idle();
    chk("rd_rvalid", rvalid, 2'b01);
    chk("rd_rdata", rdata, 16'hBEEF);

    // Reset in the cycle after a read grant drops the read.
    step(1'b0, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
    chk("rm_gnt", gnt, 2'b01);
    step(1'b1, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
    chk("rm_gnt_in_reset", gnt, 2'b00);
    idle();
    chk("rm_mem_en", mem_en, 1'b0);
    chk("rm_mem_addr", mem_addr, 16'h0);
    chk("rm_rvalid", rvalid, 2'b00);
    chk("rm_rdata", rdata, 16'h0);
    idle();
    chk("rm_rvalid_late", rvalid, 2'b00);

    // Tie after reset: 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b11, 2'b00, 2'b00, 16'h0030, 16'h0, 16'h0040, 16'h0);
      chk("tie_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle();
    chk("tie_mem_en", mem_en, 1'b1);
    chk("tie_rvalid_a", rvalid, 2'b01);
    idle();
    chk("tie_rvalid_b", rvalid, 2'b10);

    // Requester 0 holds a lock while requester 1 waits.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b11, 2'b00, 2'b01, 16'h0050, 16'h0, 16'h0060, 16'h0);
      chk("stv_locked_gnt", gnt, 2'b01);
    end
    step(1'b0, 2'b11, 2'b00, 2'b00, 16'h0050, 16'h0, 16'h0060, 16'h0);
    chk("stv_unlock_gnt", gnt, 2'b01);
    step(1'b0, 2'b11, 2'b00, 2'b00, 16'h0050, 16'h0, 16'h0060, 16'h0);
    chk("stv_forced_gnt", gnt, 2'b10);

    // Locked read-modify-write by requester 1 with requester 0 pending.
    step(1'b0, 2'b01, 2'b00, 2'b00, 16'h0080, 16'h0, 16'h0, 16'h0);
    chk("rmw_pre_gnt", gnt, 2'b01);
    step(1'b0, 2'b11, 2'b00, 2'b10, 16'h0080, 16'h0, 16'h0020, 16'h0);
    chk("rmw_rd_gnt", gnt, 2'b10);
    step(1'b0, 2'b01, 2'b00, 2'b10, 16'h0080, 16'h0, 16'h0020, 16'h0);
    chk("rmw_hold_gnt", gnt, 2'b00);
    step(1'b0, 2'b11, 2'b10, 2'b00, 16'h0080, 16'h0, 16'h0020, 16'h1234);
    chk("rmw_wr_gnt", gnt, 2'b10);
    step(1'b0, 2'b01, 2'b00, 2'b00, 16'h0080, 16'h0, 16'h0, 16'h0);
    chk("rmw_release_gnt", gnt, 2'b01);
    chk("rmw_mem_w_en", mem_w_en, 1'b1);
    chk("rmw_mem_wdata", mem_wdata, 16'h1234);
    chk("rmw_mem_addr", mem_addr, 16'h0020);
    idle();
    chk("rmw_wr_no_rvalid", rvalid, 2'b00);

    // Write then read the same address back to back.
    step(1'b0, 2'b01, 2'b01, 2'b00, 16'h0070, 16'hCAFE, 16'h0, 16'h0);
    chk("wr_gnt", gnt, 2'b01);
    step(1'b0, 2'b01, 2'b00, 2'b00, 16'h0070, 16'h0, 16'h0, 16'h0);
    chk("wr_rd_gnt", gnt, 2'b01);
    idle();
    idle();
    chk("wr_rd_rvalid", rvalid, 2'b01);
    chk("wr_rd_rdata", rdata, 16'hCAFE);

    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
